rom_stream_writer: RTL
======================

ROM_STREAM_WRITER -- requirements
Module: rom_stream_writer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, number of 16-bit word entries buffered toward SDRAM (power of two, >=2).
REQ-002 SHALL have port wclk input 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port reset input 1, asynchronous, active-high.
REQ-004 SHALL have port rom_loading input 1, load window level from iosys; 0->1 starts a load, 1->0 ends it.
REQ-005 SHALL have port rom_do input 8, ROM byte.
REQ-006 SHALL have port rom_do_valid input 1, byte strobe, up to 1 byte per cycle, bursts of 4.
REQ-007 SHALL have port rom_mask input 24, ROM address mask from the iosys header.
REQ-008 SHALL have port sd_addr output 23, SDRAM byte address, bit0 always 0.
REQ-009 SHALL have port sd_din output 16, write data, little-endian (even byte in [7:0]).
REQ-010 SHALL have port sd_ds output 2, byte enables.
REQ-011 SHALL have port sd_wr output 1, write request level.
REQ-012 SHALL have port sd_wait input 1, SDRAM not ready; a write is accepted in any cycle with sd_wr=1 and sd_wait=0.
REQ-013 SHALL have port busy output 1, high in LOAD and FLUSH.
REQ-014 SHALL have port done output 1, one-cycle pulse at load completion.
REQ-015 SHALL have port byte_count output 24, bytes accepted in the current/last load.
REQ-016 SHALL have port overflow output 1, sticky, a word was dropped because the FIFO was full.

Function
REQ-017 SHALL use states IDLE, LOAD, FLUSH; rising edge of rom_loading (registered, 1-cycle detect) moves any state to LOAD and clears the FIFO, pending half-word, byte_count and overflow, with sd_wr cleared.
REQ-018 SHALL, in LOAD, accept every rom_do_valid byte, increment byte_count mod 2^24, and keep bytes with byte_count[0]=0 as the pending low half.
REQ-019 SHALL, on an odd byte, push {addr=(byte_count & rom_mask) with bit0=0, data={byte, low}, ds=2'b11} to the FIFO the next cycle.
REQ-020 SHALL mask the address with rom_mask so writes wrap inside the ROM region; bits above 22 are discarded.
REQ-021 SHALL drop the word, set overflow, and still advance byte_count when a push meets a full FIFO.
REQ-022 SHALL present the FIFO head on sd_addr/sd_din/sd_ds with sd_wr=1 whenever the FIFO is non-empty, holding all four stable until accepted, then pop; a second byte at cycle N yields sd_wr=1 at cycle N+2 when the FIFO was empty and no write was outstanding.
REQ-023 SHALL allow simultaneous push and pop at the full boundary without flagging overflow (pop frees space in the same cycle).
REQ-024 SHALL, on the falling edge of rom_loading, first accept a byte valid in that same cycle, then push any pending even byte with ds=2'b01 and data[15:8]=0, then enter FLUSH.
REQ-025 SHALL leave FLUSH when the FIFO is empty and no write is outstanding: pulse done for one cycle and go to IDLE.
REQ-026 SHALL ignore rom_do_valid in IDLE and FLUSH.
REQ-027 SHALL treat a rising edge in FLUSH as an abort: the FIFO is discarded, done is not pulsed, and a new LOAD starts.

Reset
REQ-028 SHALL on reset enter IDLE with sd_wr=0, sd_addr=0, sd_din=0, sd_ds=0, busy=0, done=0, byte_count=0, overflow=0, FIFO empty, and the edge-detect register=0.
REQ-029 SHALL drop any in-flight write on reset mid-operation, with no resume.

Structure
REQ-030 SHALL take state encodings (IDLE=0, LOAD=1, FLUSH=2) and the FIFO entry width (41 bits: 23 addr + 16 data + 2 ds) from shared package iosys_pkg.
REQ-031 SHALL implement the buffer as one sub-module, sync_fifo (parameterised width/depth, full/empty, registered outputs).

Verification
REQ-032 SHALL cover this scenario: load bytes 0x11,0x22,0x33,0x44 back-to-back with sd_wait=0 and rom_mask=0xFFFFFF -> writes (0x000000,0x2211,11) and (0x000002,0x4433,11); done pulses 1 cycle after the last accept; byte_count=4.
REQ-033 SHALL cover this scenario: 5 bytes 0x01..0x05 -> third write (0x000004,0x0005,01); byte_count=5.
REQ-034 SHALL cover this scenario: sd_wait=1 for 40 cycles during a 32-byte stream with FIFO_DEPTH=8 -> exactly 8 words retained, overflow=1, byte_count=32, and sd_addr/sd_din held stable while waiting.
REQ-035 SHALL cover this scenario: rom_mask=0x0003FF, 1026 bytes -> the last write goes to address 0x000000, data = bytes 1024/1025.
REQ-036 SHALL cover this scenario: reset asserted mid-burst with sd_wr=1 -> sd_wr=0 immediately (asynchronously); after release, a new load restarts at address 0.
REQ-037 SHALL cover this scenario: rom_loading re-asserted during FLUSH with 3 words queued -> no done pulse, FIFO empty, and the next write goes to address 0.

Source files
------------

// File: rtl/iosys_pkg.sv
// Shared iosys definitions: loader FSM encodings and the SDRAM write entry layout.
package iosys_pkg;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    localparam int ADDR_W  = 23;
    localparam int DATA_W  = 16;
    localparam int DS_W    = 2;
    localparam int ENTRY_W = ADDR_W + DATA_W + DS_W;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [DS_W-1:0]   ds;
    } wr_entry_t;

    // Word address of a byte position inside the masked ROM region.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [23:0] count, input logic [23:0] mask);
        return ADDR_W'(count & mask & 24'hFF_FFFE);
    endfunction
endpackage

// File: rtl/rom_stream_writer_if.sv
// SDRAM write port: level request held with its payload until sd_wait is low.
interface rom_stream_writer_if;
    logic [22:0] sd_addr;
    logic [15:0] sd_din;
    logic [1:0]  sd_ds;
    logic        sd_wr;
    logic        sd_wait;

    modport master (output sd_addr, sd_din, sd_ds, sd_wr, input sd_wait);
    modport slave  (input sd_addr, sd_din, sd_ds, sd_wr, output sd_wait);
endinterface

// File: rtl/sync_fifo.sv
// Register-array FIFO with registered full/empty; head is read straight from the array.
module sync_fifo #(
    parameter int WIDTH = 41,
    parameter int DEPTH = 8
) (
    input  logic             wclk,
    input  logic             reset,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count, count_nxt;
    logic          do_push, do_pop;

    // A pop frees a slot in the same cycle, so a push at full still lands.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (do_push && !do_pop)
            count_nxt = count + 1'b1;
        else if (!do_push && do_pop)
            count_nxt = count - 1'b1;
    end

    always_ff @(posedge wclk or posedge reset) begin
        if (reset) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
            full  <= (count_nxt == (AW+1)'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end
endmodule

// File: rtl/rom_stream_writer.sv
// Packs the iosys ROM byte stream into 16-bit SDRAM writes inside a masked region.
module rom_stream_writer
    import iosys_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 wclk,
    input  logic                 reset,
    input  logic                 rom_loading,
    input  logic [7:0]           rom_do,
    input  logic                 rom_do_valid,
    input  logic [23:0]          rom_mask,
    rom_stream_writer_if.master  sd,
    output logic                 busy,
    output logic                 done,
    output logic [23:0]          byte_count,
    output logic                 overflow
);
    logic [1:0] state;
    logic       load_q;
    logic [7:0] low;
    logic       push_vld;
    wr_entry_t  push_ent, head;
    logic       fifo_full, fifo_empty;
    logic       rise, fall, pop, flush_done;

    assign rise       = rom_loading && !load_q;
    assign fall       = !rom_loading && load_q;
    assign pop        = !fifo_empty && !sd.sd_wait;
    assign flush_done = (state == ST_FLUSH) && fifo_empty && !push_vld;
    assign done       = flush_done && !rise;
    assign busy       = (state != ST_IDLE);

    assign sd.sd_addr = head.addr;
    assign sd.sd_din  = head.data;
    assign sd.sd_ds   = head.ds;
    assign sd.sd_wr   = !fifo_empty;

    always_ff @(posedge wclk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            load_q     <= 1'b0;
            low        <= '0;
            push_vld   <= 1'b0;
            push_ent   <= '0;
            byte_count <= '0;
            overflow   <= 1'b0;
        end else begin
            load_q   <= rom_loading;
            push_vld <= 1'b0;
            if (push_vld && fifo_full && !pop)
                overflow <= 1'b1;
            // A new load window wins over everything, including a pending push.
            if (rise) begin
                state      <= ST_LOAD;
                low        <= '0;
                byte_count <= '0;
                overflow   <= 1'b0;
            end else begin
                case (state)
                    ST_LOAD: begin
                        if (rom_do_valid) begin
                            byte_count <= byte_count + 24'd1;
                            if (byte_count[0]) begin
                                push_vld <= 1'b1;
                                push_ent <= '{addr: word_addr(byte_count, rom_mask),
                                              data: {rom_do, low}, ds: 2'b11};
                            end else begin
                                low <= rom_do;
                                if (fall) begin
                                    push_vld <= 1'b1;
                                    push_ent <= '{addr: word_addr(byte_count, rom_mask),
                                                  data: {8'h00, rom_do}, ds: 2'b01};
                                end
                            end
                        end else if (fall && byte_count[0]) begin
                            push_vld <= 1'b1;
                            push_ent <= '{addr: word_addr(byte_count, rom_mask),
                                          data: {8'h00, low}, ds: 2'b01};
                        end
                        if (fall)
                            state <= ST_FLUSH;
                    end
                    ST_FLUSH: if (flush_done) state <= ST_IDLE;
                    default:  state <= ST_IDLE;
                endcase
            end
        end
    end

    sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .wclk  (wclk),
        .reset (reset),
        .clr   (rise),
        .push  (push_vld),
        .pop   (pop),
        .din   (push_ent),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );
endmodule
